dbus_responder: RTL



---
 rtl/dbus_if.sv | 23 ++
 rtl/dbus_responder.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/dbus_if.sv
// Data-bus handshake bundle between the core (master) and a memory responder
// (slave). The bidirectional data lines stay a separate inout wire so they can
// be resolved as a plain tri-state net.
interface dbus_if;
   logic        dreq;
   logic        dwrite;
   logic [1:0]  dsize;
   logic [31:0] daddr;
   logic        stall_in;
   logic        dbusy;
   logic        dready_n;
   logic        access_err;

   modport master (
      output dreq, dwrite, dsize, daddr, stall_in,
      input  dbusy, dready_n, access_err
   );

   modport slave (
      input  dreq, dwrite, dsize, daddr, stall_in,
      output dbusy, dready_n, access_err
   );
endinterface

// File: rtl/dbus_responder.sv
// Wait-stated data-RAM responder for the core data bus. One access at a time:
// IDLE accepts, WAIT burns the configured wait states (optionally stretched by
// stall_in), RESP completes with a one-cycle active-low ready strobe. Loads
// drive ddata only during RESP; stores write the RAM on the edge ending RESP.
module dbus_responder #(
   parameter int          ADDR_LOG2   = 12,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic      clk,
   input  logic      rst,
   dbus_if.slave     bus,
   inout  wire [31:0] ddata
);
   localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2} state_t;

   state_t        state;
   logic [3:0]    cnt;
   logic [31:0]   addr_q;
   logic [1:0]    size_q;
   logic          write_q;
   logic [31:0]   wdata_q;
   logic          busy;
   logic          ready_n;
   logic          err;
   logic          drive;
   logic [31:0]   rdata;

   logic [31:0]   mem [0:(1 << ADDR_LOG2) - 1];

   // The access being resolved: live bus inputs while IDLE, latched copy after.
   logic [31:0]          sel_addr;
   logic [1:0]           sel_size;
   logic                 sel_write;
   logic [32:0]          offset;
   logic                 in_range;
   logic                 size_fault;
   logic                 fault;
   logic [ADDR_LOG2-1:0] idx;
   logic [31:0]          word;
   logic [31:0]          load_data;
   logic [3:0]           be;
   logic [31:0]          wword;

   assign bus.dbusy      = busy;
   assign bus.dready_n   = ready_n;
   assign bus.access_err = err;
   assign ddata          = drive ? rdata : 32'bz;

   // Decode address range, alignment, read lane extraction and write lanes.
   always_comb begin
      sel_addr   = (state == S_IDLE) ? bus.daddr  : addr_q;
      sel_size   = (state == S_IDLE) ? bus.dsize  : size_q;
      sel_write  = (state == S_IDLE) ? bus.dwrite : write_q;
      offset     = {1'b0, sel_addr} - {1'b0, BASE_ADDR};
      in_range   = ~offset[32] && ((offset[31:0] >> (ADDR_LOG2 + 2)) == 32'd0);
      idx        = offset[ADDR_LOG2+1:2];
      word       = mem[idx];
      size_fault = 1'b0;
      load_data  = 32'h0;
      be         = 4'b0000;
      wword      = 32'h0;
      case (sel_size)
         2'b00: begin
            load_data = {24'h0, word[8*sel_addr[1:0] +: 8]};
            be        = 4'b0001 << sel_addr[1:0];
            wword     = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            size_fault = sel_addr[0];
            if (sel_addr[1]) begin
               load_data = {16'h0, word[31:16]};
               be        = 4'b1100;
            end else begin
               load_data = {16'h0, word[15:0]};
               be        = 4'b0011;
            end
            wword = {2{wdata_q[15:0]}};
         end
         2'b10: begin
            size_fault = |sel_addr[1:0];
            load_data  = word;
            be         = 4'b1111;
            wword      = wdata_q;
         end
         default: begin
            size_fault = 1'b1;
         end
      endcase
      fault = size_fault | ~in_range;
   end

   // Access sequencer with registered handshake outputs and bus drive enable.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         addr_q  <= 32'h0;
         size_q  <= 2'b00;
         write_q <= 1'b0;
         wdata_q <= 32'h0;
         busy    <= 1'b0;
         ready_n <= 1'b1;
         err     <= 1'b0;
         drive   <= 1'b0;
         rdata   <= 32'h0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.dreq) begin
                  addr_q  <= bus.daddr;
                  size_q  <= bus.dsize;
                  write_q <= bus.dwrite;
                  wdata_q <= ddata;
                  busy    <= 1'b1;
                  if (WAIT_CYCLES > 0) begin
                     state <= S_WAIT;
                     cnt   <= WAIT_LOAD;
                  end else begin
                     state   <= S_RESP;
                     ready_n <= 1'b0;
                     err     <= fault;
                     drive   <= ~sel_write;
                     rdata   <= fault ? 32'h0 : load_data;
                  end
               end
            end
            S_WAIT: begin
               if (bus.stall_in) begin
                  cnt <= cnt;
               end else if (cnt == 4'd0) begin
                  state   <= S_RESP;
                  ready_n <= 1'b0;
                  err     <= fault;
                  drive   <= ~sel_write;
                  rdata   <= fault ? 32'h0 : load_data;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               state   <= S_IDLE;
               busy    <= 1'b0;
               ready_n <= 1'b1;
               err     <= 1'b0;
               drive   <= 1'b0;
               rdata   <= 32'h0;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // RAM lane write on the edge ending RESP of a non-faulting store; reset
   // forces the state out of RESP so an interrupted store never lands.
   always_ff @(posedge clk) begin
      if (state == S_RESP && write_q && !err) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
               mem[idx][8*i +: 8] <= wword[8*i +: 8];
            end
         end
      end
   end
endmodule
